// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern buses for the LEDR selector.
//   - victory running light, defeat full-bar blink, latched hint bar graph
//   - free-running animation prescaler with a one-cycle anim_tick pulse
// Optional feature macro: LED_DICA_FLASH_EN. When defined, the hint bar
// blinks for 4 ticks after each new hint; otherwise the bar is steady.
module led_pattern_gen #(
    parameter int TICK_DIV = 5000000,
    parameter int NLEDS    = 18
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             senha_correta,
    input  logic             derrota,
    input  logic             hint_valid,
    input  logic [4:0]       hint_score,
    output logic [NLEDS-1:0] leds_vitoria,
    output logic [NLEDS-1:0] leds_derrota,
    output logic [NLEDS-1:0] leds_dica,
    output logic             anim_tick
);

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam int              POSW       = (NLEDS > 2) ? $clog2(NLEDS) : 1;
    localparam logic [POSW-1:0] POS_LAST   = POSW'(NLEDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VICTORY = 2'd1,
        ST_DEFEAT  = 2'd2
    } state_t;

    // Bar graph with the lowest min(score, NLEDS) bits set; saturation falls
    // out of the per-bit compare.
    function automatic logic [NLEDS-1:0] bar_mask(input logic [4:0] score);
        logic [NLEDS-1:0] m;
        for (int i = 0; i < NLEDS; i++) begin
            m[i] = (i < int'(score));
        end
        return m;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_entry;
    logic [PW-1:0]     r_presc;
    logic [PW-1:0]     w_presc_nxt;
    logic              r_tick;
    logic [POSW-1:0]   r_pos;
    logic [POSW-1:0]   w_pos_nxt;
    logic              r_phase;
    logic              w_phase_nxt;
    logic [NLEDS-1:0]  r_vit;
    logic [NLEDS-1:0]  r_der;
    logic [NLEDS-1:0]  r_bar;
    logic [NLEDS-1:0]  w_bar_nxt;
    logic [NLEDS-1:0]  r_dica;
    logic [NLEDS-1:0]  w_dica_nxt;
    logic [NLEDS-1:0]  w_onehot;

    // Next-state decode; w_entry flags any transition into an animated state.
    always_comb begin
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (senha_correta) begin
                    w_state_nxt = ST_VICTORY;
                    w_entry     = 1'b1;
                end else if (derrota) begin
                    w_state_nxt = ST_DEFEAT;
                    w_entry     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VICTORY: begin
                if (!senha_correta) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_VICTORY;
                end
            end
            ST_DEFEAT: begin
                if (senha_correta) begin
                    w_state_nxt = ST_VICTORY;
                    w_entry     = 1'b1;
                end else if (!derrota) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DEFEAT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Prescaler, chaser position and blink phase next values; entry restarts all.
    always_comb begin
        w_presc_nxt = r_presc;
        w_pos_nxt   = r_pos;
        w_phase_nxt = r_phase;
        if (w_entry) begin
            w_presc_nxt = '0;
            w_pos_nxt   = '0;
            w_phase_nxt = 1'b1;
        end else begin
            if (r_presc == PRESC_LAST) begin
                w_presc_nxt = '0;
            end else begin
                w_presc_nxt = r_presc + 1'b1;
            end
            if (r_tick) begin
                w_phase_nxt = ~r_phase;
                if (r_pos == POS_LAST) begin
                    w_pos_nxt = '0;
                end else begin
                    w_pos_nxt = r_pos + 1'b1;
                end
            end else begin
                w_pos_nxt   = r_pos;
                w_phase_nxt = r_phase;
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prescaler and tick; r_tick is high exactly while r_presc sits at its last count.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == PRESC_LAST);
        end
    end

    // Animation phase registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pos   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_pos   <= w_pos_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign w_onehot = {{(NLEDS-1){1'b0}}, 1'b1} << r_pos;

    // Registered animation outputs, forced to zero outside their own state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_vit <= '0;
            r_der <= '0;
        end else begin
            r_vit <= (r_state == ST_VICTORY) ? w_onehot : '0;
            r_der <= ((r_state == ST_DEFEAT) && r_phase) ? '1 : '0;
        end
    end

    assign w_bar_nxt = hint_valid ? bar_mask(hint_score) : r_bar;

`ifdef LED_DICA_FLASH_EN
    logic [2:0] r_flash_cnt;
    logic [2:0] w_flash_cnt_nxt;

    // Remaining flash ticks: odd counts blank the bar, even counts (and 0) show it.
    always_comb begin
        w_flash_cnt_nxt = r_flash_cnt;
        if (hint_valid) begin
            w_flash_cnt_nxt = 3'd4;
        end else if (r_tick && (r_flash_cnt != 3'd0)) begin
            w_flash_cnt_nxt = r_flash_cnt - 3'd1;
        end else begin
            w_flash_cnt_nxt = r_flash_cnt;
        end
        w_dica_nxt = w_flash_cnt_nxt[0] ? '0 : w_bar_nxt;
    end

    // Flash counter register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_flash_cnt <= 3'd0;
        end else begin
            r_flash_cnt <= w_flash_cnt_nxt;
        end
    end
`else
    assign w_dica_nxt = w_bar_nxt;
`endif

    // Latched hint bar and its registered display value; cleared only by reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_bar  <= '0;
            r_dica <= '0;
        end else begin
            r_bar  <= w_bar_nxt;
            r_dica <= w_dica_nxt;
        end
    end

    assign leds_vitoria = r_vit;
    assign leds_derrota = r_der;
    assign leds_dica    = r_dica;
    assign anim_tick    = r_tick;

endmodule
